// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: baud/oversample tick generator plus a DEPTH-entry
// first-word-fall-through frame FIFO between the host write port and the
// UART transmitter.
// Optional feature macro: UART_ALARM_EN. When it is defined, writes of
// ALARM_CODE and SHUTDOWN_CODE raise the sticky alarm and shutdown flags.
// When it is undefined, there are no reserved codes and both flags are tied 0.
//
// Handshake (tx side): tx_valid high means the head fields data_in_tx, d_num,
// par and s_num are meaningful. They stay stable until the cycle in which
// tx_valid & tx_ready are both high at the rising edge. That edge pops the head.
module uart_link_ctrl #(
  parameter int         DIV0          = 2604,
  parameter int         DIV1          = 1302,
  parameter int         DIV2          = 12,
  parameter int         DIV3          = 326,
  parameter int         OVS           = 16,
  parameter int         DEPTH         = 8,
  parameter logic [8:0] ALARM_CODE    = 9'd250,
  parameter logic [8:0] SHUTDOWN_CODE = 9'd300
) (
  input  logic       clkdiv,
  input  logic       reset,
  input  logic [1:0] bd_rate,
  input  logic [1:0] par_check,
  input  logic       s_num_sig,
  input  logic       wr_en,
  input  logic [8:0] data_in,
  input  logic       alarm_clr,
  output logic       full,
  output logic       err_sig,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] data_in_tx,
  output logic       d_num,
  output logic [1:0] par,
  output logic       s_num,
  output logic       bd_rate_gen,
  output logic       bd_rate_tx,
  output logic       alarm_sig,
  output logic       shut_down_sig
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int EW = 12;  // {s_num, par[1:0], d_num, data[7:0]}

  logic          shut_q;
  logic          alarm_q;

  // ---------------- baud divider and oversample counter ----------------
  logic [11:0]   div_sel;
  logic [1:0]    bd_rate_q;
  logic [11:0]   div_cnt;
  logic [OW-1:0] ovs_cnt;
  logic          gen_q;
  logic          tx_q;
  logic          rate_chg;
  logic          div_wrap;

  // Select the active divisor from bd_rate.
  always_comb begin
    div_sel = 12'(DIV0);
    case (bd_rate)
      2'b01:   div_sel = 12'(DIV1);
      2'b10:   div_sel = 12'(DIV2);
      2'b11:   div_sel = 12'(DIV3);
      default: div_sel = 12'(DIV0);
    endcase
  end

  assign rate_chg = (bd_rate != bd_rate_q);
  assign div_wrap = !rate_chg && (div_cnt == div_sel);

  // Divider counts 0..div_sel. A rate change restarts it without a tick.
  // The oversample counter advances on each divider wrap.
  always_ff @(posedge clkdiv) begin
    if (!reset) begin
      bd_rate_q <= 2'b00;
      div_cnt   <= '0;
      ovs_cnt   <= '0;
      gen_q     <= 1'b0;
      tx_q      <= 1'b0;
    end else begin
      bd_rate_q <= bd_rate;
      if (shut_q || rate_chg) begin
        div_cnt <= '0;
        if (shut_q) ovs_cnt <= '0;
        gen_q   <= 1'b0;
        tx_q    <= 1'b0;
      end else if (div_wrap) begin
        div_cnt <= '0;
        gen_q   <= 1'b1;
        if (ovs_cnt == OW'(OVS - 1)) begin
          ovs_cnt <= '0;
          tx_q    <= 1'b1;
        end else begin
          ovs_cnt <= ovs_cnt + OW'(1);
          tx_q    <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 12'd1;
        gen_q   <= 1'b0;
        tx_q    <= 1'b0;
      end
    end
  end

  assign bd_rate_gen = gen_q & ~shut_q;
  assign bd_rate_tx  = tx_q & ~shut_q;

  // ---------------- write classification ----------------
  logic          is_shut_wr;
  logic          is_alarm_wr;
  logic          wr_act;
  logic          push;
  logic          drop;
  logic          pop;
  logic [1:0]    par_q;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] mem [DEPTH];

  assign wr_act = wr_en && !shut_q;

`ifdef UART_ALARM_EN
  assign is_shut_wr  = wr_act && (data_in == SHUTDOWN_CODE);
  assign is_alarm_wr = wr_act && (data_in == ALARM_CODE);

  // Sticky flags: alarm set beats clear, shutdown holds until reset.
  always_ff @(posedge clkdiv) begin
    if (!reset) begin
      alarm_q <= 1'b0;
      shut_q  <= 1'b0;
    end else begin
      if (is_shut_wr) shut_q <= 1'b1;
      if (is_alarm_wr)    alarm_q <= 1'b1;
      else if (alarm_clr) alarm_q <= 1'b0;
    end
  end
`else
  logic [8:0] unused_codes;
  assign unused_codes = ALARM_CODE ^ SHUTDOWN_CODE ^ {8'b0, alarm_clr};
  assign is_shut_wr   = 1'b0;
  assign is_alarm_wr  = 1'b0;
  assign alarm_q      = 1'b0;
  assign shut_q       = 1'b0;
`endif

  assign full  = (count == CW'(DEPTH));
  assign drop  = wr_act && !is_shut_wr && !is_alarm_wr && (data_in[8] || full);
  assign push  = wr_act && !is_shut_wr && !is_alarm_wr && !data_in[8] && !full;
  assign pop   = tx_valid && tx_ready;

  // Parity register follows par_check except for the "keep previous" code.
  always_ff @(posedge clkdiv) begin
    if (!reset) par_q <= 2'b00;
    else if (par_check != 2'b11) par_q <= par_check;
  end

  // Dropped-word pulse.
  always_ff @(posedge clkdiv) begin
    if (!reset) err_sig <= 1'b0;
    else        err_sig <= drop;
  end

  // ---------------- FIFO ----------------
  // Pointer and occupancy bookkeeping. A shutdown write flushes everything.
  always_ff @(posedge clkdiv) begin
    if (!reset || is_shut_wr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. Each frame keeps the format that was live at its push.
  always_ff @(posedge clkdiv) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {s_num_sig, par_q, data_in[7], data_in[7:0]};
    end
  end

  assign tx_valid = (count != '0) && !shut_q;
  assign {s_num, par, d_num, data_in_tx} = mem[rd_ptr];

  assign alarm_sig     = alarm_q;
  assign shut_down_sig = shut_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Self-checking bench for uart_link_ctrl. It uses a queue-based reference
// model of the frame FIFO and flags, and it measures tick intervals.
`timescale 1ns/1ps
module tb_uart_link_ctrl;
  localparam int         DIV0 = 2604, DIV1 = 1302, DIV2 = 12, DIV3 = 326;
  localparam int         OVS = 16, DEPTH = 8;
  localparam logic [8:0] ALARM_CODE = 9'd250, SHUTDOWN_CODE = 9'd300;
`ifdef UART_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic       clkdiv, reset, s_num_sig, wr_en, alarm_clr, tx_ready;
  logic [1:0] bd_rate, par_check;
  logic [8:0] data_in;
  logic       full, err_sig, tx_valid, d_num, s_num, bd_rate_gen, bd_rate_tx;
  logic       alarm_sig, shut_down_sig;
  logic [7:0] data_in_tx;
  logic [1:0] par;

  uart_link_ctrl #(
    .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3), .OVS(OVS),
    .DEPTH(DEPTH), .ALARM_CODE(ALARM_CODE), .SHUTDOWN_CODE(SHUTDOWN_CODE)
  ) dut (
    .clkdiv(clkdiv), .reset(reset), .bd_rate(bd_rate), .par_check(par_check),
    .s_num_sig(s_num_sig), .wr_en(wr_en), .data_in(data_in),
    .alarm_clr(alarm_clr), .full(full), .err_sig(err_sig),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .data_in_tx(data_in_tx),
    .d_num(d_num), .par(par), .s_num(s_num), .bd_rate_gen(bd_rate_gen),
    .bd_rate_tx(bd_rate_tx), .alarm_sig(alarm_sig),
    .shut_down_sig(shut_down_sig)
  );

  // ---------------- clock ----------------
  initial begin
    clkdiv = 1'b0;
    forever #5 clkdiv = ~clkdiv;
  end

  // ---------------- reference model state ----------------
  logic [11:0] exp_q[$];   // {s_num, par, d_num, data}
  logic [1:0]  m_par;
  logic        m_alarm, m_shut, m_err;
  int          n_checks, n_errors;

  // Advance one clock: update the model from the inputs present before the edge.
  task automatic step();
    bit full_m, pop_m;
    full_m = (exp_q.size() == DEPTH);
    pop_m  = tx_ready && (exp_q.size() > 0) && !m_shut;
    m_err  = 1'b0;
    if (pop_m) void'(exp_q.pop_front());
    if (wr_en && !m_shut) begin
      if (ALARM_EN && data_in == SHUTDOWN_CODE) begin
        m_shut = 1'b1;
        exp_q.delete();
      end else if (ALARM_EN && data_in == ALARM_CODE) begin
        // flag only, handled below
      end else if (data_in[8] || full_m) begin
        m_err = 1'b1;
      end else begin
        exp_q.push_back({s_num_sig, m_par, data_in[7], data_in[7:0]});
      end
    end
    if (ALARM_EN) begin
      if (wr_en && !m_shut && data_in == ALARM_CODE) m_alarm = 1'b1;
      else if (alarm_clr) m_alarm = 1'b0;
    end
    if (par_check != 2'b11) m_par = par_check;
    @(posedge clkdiv);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; wr_en = 1'b0; data_in = '0; alarm_clr = 1'b0; tx_ready = 1'b0;
    par_check = 2'b00; s_num_sig = 1'b0;
    @(posedge clkdiv); @(posedge clkdiv); #1;
    reset = 1'b1;
    exp_q.delete(); m_par = 2'b00; m_alarm = 1'b0; m_shut = 1'b0; m_err = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    wr_en = 1'b0; tx_ready = 1'b1;
    while (exp_q.size() > 0 && guard < 4 * DEPTH) begin
      n_checks++;
      if ({tx_valid, data_in_tx, d_num, par, s_num} !==
          {1'b1, exp_q[0][7:0], exp_q[0][8], exp_q[0][10:9], exp_q[0][11]}) begin
        n_errors++;
        $display("FAIL drain_head: got v=%b d=%h dn=%b p=%b s=%b want %h", tx_valid,
                 data_in_tx, d_num, par, s_num, exp_q[0]);
      end
      step();
      guard++;
    end
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL drain_empty: tx_valid=%b want 0", tx_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bd_rate = 2'b00;
    do_reset();
    n_checks++;
    if ({full, err_sig, tx_valid, data_in_tx, d_num, par, s_num, bd_rate_gen,
         bd_rate_tx, alarm_sig, shut_down_sig} !== 18'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: full=%b err=%b v=%b d=%h gen=%b tx=%b al=%b sd=%b want all 0",
               full, err_sig, tx_valid, data_in_tx, bd_rate_gen, bd_rate_tx, alarm_sig, shut_down_sig);
    end
  endtask

  task automatic test_baud();
    int n;
    bd_rate = 2'b10;
    n = 0;
    while (bd_rate_gen !== 1'b1 && n < 2000) begin @(posedge clkdiv); #1; n++; end
    n_checks++;
    if (n >= 2000) begin n_errors++; $display("FAIL gen_start: no tick in %0d cycles, want one", n); end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin @(posedge clkdiv); #1; n++; end while (bd_rate_gen !== 1'b1 && n < 2000);
      n_checks++;
      if (n != DIV2 + 1) begin
        n_errors++; $display("FAIL gen_period: %0d cycles, want %0d", n, DIV2 + 1);
      end
    end
    n = 0;
    while (bd_rate_tx !== 1'b1 && n < 1000) begin @(posedge clkdiv); #1; n++; end
    n_checks++;
    if (bd_rate_gen !== 1'b1) begin
      n_errors++; $display("FAIL tx_with_gen: gen=%b at tx pulse, want 1", bd_rate_gen);
    end
    n = 0;
    do begin @(posedge clkdiv); #1; n++; end while (bd_rate_tx !== 1'b1 && n < 2000);
    n_checks++;
    if (n != OVS * (DIV2 + 1)) begin
      n_errors++; $display("FAIL tx_period: %0d cycles, want %0d", n, OVS * (DIV2 + 1));
    end
    // Switch rate: the first edge sampling the new value restarts the divider.
    bd_rate = 2'b11;
    @(posedge clkdiv); #1;
    n_checks++;
    if (bd_rate_gen !== 1'b0) begin
      n_errors++; $display("FAIL switch_no_tick: gen=%b want 0", bd_rate_gen);
    end
    n = 0;
    while (bd_rate_gen !== 1'b1 && n < 1000) begin @(posedge clkdiv); #1; n++; end
    n_checks++;
    if (n != DIV3 + 1) begin
      n_errors++; $display("FAIL switch_first_tick: %0d cycles, want %0d", n, DIV3 + 1);
    end
  endtask

  task automatic test_format();
    par_check = 2'b10; s_num_sig = 1'b1; tx_ready = 1'b0; wr_en = 1'b0;
    step();
    wr_en = 1'b1; data_in = 9'h041; step();
    n_checks++;
    if ({tx_valid, data_in_tx, d_num, par, s_num} !== {1'b1, 8'h41, 1'b0, 2'b10, 1'b1}) begin
      n_errors++;
      $display("FAIL fmt_head7: v=%b d=%h dn=%b p=%b s=%b want 1 41 0 10 1",
               tx_valid, data_in_tx, d_num, par, s_num);
    end
    data_in = 9'h0C3; step(); wr_en = 1'b0;
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    n_checks++;
    if ({tx_valid, data_in_tx, d_num} !== {1'b1, 8'hC3, 1'b1}) begin
      n_errors++;
      $display("FAIL fmt_head8: v=%b d=%h dn=%b want 1 c3 1", tx_valid, data_in_tx, d_num);
    end
    drain();
  endtask

  task automatic test_full();
    logic [7:0] b;
    tx_ready = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (ALARM_EN && b == 8'd250) b = 8'd251;
      data_in = {1'b0, b};
      step();
      if (i == DEPTH - 1) begin
        n_checks++;
        if ({full, err_sig} !== 2'b10) begin
          n_errors++; $display("FAIL full_set: full=%b err=%b want 1 0", full, err_sig);
        end
      end
      if (i == DEPTH) begin
        n_checks++;
        if ({full, err_sig} !== 2'b11) begin
          n_errors++; $display("FAIL full_drop: full=%b err=%b want 1 1", full, err_sig);
        end
      end
    end
    // Pop and write in the same full cycle: the write is still dropped.
    data_in = 9'h055; tx_ready = 1'b1; step(); wr_en = 1'b0; tx_ready = 1'b0;
    n_checks++;
    if ({full, err_sig, tx_valid} !== {1'b0, m_err, 1'b1} || exp_q.size() != DEPTH - 1) begin
      n_errors++;
      $display("FAIL full_pop_write: full=%b err=%b v=%b want 0 1 1", full, err_sig, tx_valid);
    end
    step();
    n_checks++;
    if (err_sig !== 1'b0) begin n_errors++; $display("FAIL err_pulse: err=%b want 0", err_sig); end
    drain();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      wr_en = ($urandom_range(0, 99) < 60);
      r = $urandom_range(0, 99);
      if (r < 10)                 data_in = {1'b1, 8'($urandom)};
      else if (ALARM_EN && r < 13) data_in = ALARM_CODE;
      else                        data_in = {1'b0, 8'($urandom)};
      if (ALARM_EN && data_in == SHUTDOWN_CODE) data_in = 9'h000;
      tx_ready  = ($urandom_range(0, 99) < 40);
      par_check = 2'($urandom_range(0, 3));
      s_num_sig = 1'($urandom_range(0, 1));
      alarm_clr = ($urandom_range(0, 9) == 0);
      step();
      n_checks++;
      if ({tx_valid, full, err_sig, alarm_sig} !==
          {exp_q.size() > 0, exp_q.size() == DEPTH, m_err, m_alarm}) begin
        n_errors++;
        $display("FAIL rand_flags c=%0d: v=%b full=%b err=%b al=%b want %b %b %b %b", c,
                 tx_valid, full, err_sig, alarm_sig, exp_q.size() > 0,
                 exp_q.size() == DEPTH, m_err, m_alarm);
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        if ({data_in_tx, d_num, par, s_num} !==
            {exp_q[0][7:0], exp_q[0][8], exp_q[0][10:9], exp_q[0][11]}) begin
          n_errors++;
          $display("FAIL rand_head c=%0d: d=%h dn=%b p=%b s=%b want %h", c, data_in_tx,
                   d_num, par, s_num, exp_q[0]);
        end
      end
    end
    wr_en = 1'b0; alarm_clr = 1'b0; tx_ready = 1'b0;
    drain();
  endtask

`ifdef UART_ALARM_EN
  task automatic test_alarm();
    alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
    wr_en = 1'b1; data_in = 9'h011; step();
    data_in = ALARM_CODE; step(); wr_en = 1'b0;
    n_checks++;
    if ({alarm_sig, err_sig, tx_valid, data_in_tx} !== {1'b1, 1'b0, 1'b1, 8'h11}) begin
      n_errors++;
      $display("FAIL alarm_set: al=%b err=%b v=%b d=%h want 1 0 1 11", alarm_sig, err_sig,
               tx_valid, data_in_tx);
    end
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_errors++; $display("FAIL alarm_no_push: v=%b want 0", tx_valid);
    end
    alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
    n_checks++;
    if (alarm_sig !== 1'b0) begin n_errors++; $display("FAIL alarm_clr: al=%b want 0", alarm_sig); end
    wr_en = 1'b1; data_in = ALARM_CODE; step();
    alarm_clr = 1'b1; step(); wr_en = 1'b0;
    n_checks++;
    if (alarm_sig !== 1'b1) begin
      n_errors++; $display("FAIL alarm_set_wins: al=%b want 1", alarm_sig);
    end
    step(); alarm_clr = 1'b0;
    n_checks++;
    if (alarm_sig !== 1'b0) begin n_errors++; $display("FAIL alarm_clr2: al=%b want 0", alarm_sig); end
  endtask

  task automatic test_shutdown();
    int pulses, n;
    tx_ready = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin data_in = 9'(8'h30 + i); step(); end
    data_in = SHUTDOWN_CODE; step(); wr_en = 1'b0;
    n_checks++;
    if ({shut_down_sig, tx_valid, full} !== 3'b100) begin
      n_errors++;
      $display("FAIL shut_set: sd=%b v=%b full=%b want 1 0 0", shut_down_sig, tx_valid, full);
    end
    pulses = 0;
    for (int i = 0; i < 2 * (DIV3 + 1); i++) begin
      @(posedge clkdiv); #1;
      if (bd_rate_gen || bd_rate_tx) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_errors++; $display("FAIL shut_ticks: %0d ticks want 0", pulses); end
    wr_en = 1'b1; data_in = 9'h022; step();
    data_in = 9'h1FF; step(); wr_en = 1'b0;
    n_checks++;
    if ({err_sig, tx_valid, shut_down_sig} !== 3'b001) begin
      n_errors++;
      $display("FAIL shut_ignore: err=%b v=%b sd=%b want 0 0 1", err_sig, tx_valid, shut_down_sig);
    end
    do_reset();
    n_checks++;
    if ({shut_down_sig, tx_valid} !== 2'b00) begin
      n_errors++; $display("FAIL shut_reset: sd=%b v=%b want 0 0", shut_down_sig, tx_valid);
    end
    n = 0;
    while (bd_rate_gen !== 1'b1 && n < 1000) begin @(posedge clkdiv); #1; n++; end
    n_checks++;
    if (n >= 1000) begin n_errors++; $display("FAIL shut_ticks_back: no tick in %0d cycles", n); end
  endtask
`else
  task automatic test_no_alarm();
    tx_ready = 1'b0;
    wr_en = 1'b1; data_in = 9'd250; step(); wr_en = 1'b0;
    n_checks++;
    if ({tx_valid, data_in_tx, d_num, err_sig} !== {1'b1, 8'hFA, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL noal_250: v=%b d=%h dn=%b err=%b want 1 fa 1 0", tx_valid, data_in_tx,
               d_num, err_sig);
    end
    wr_en = 1'b1; data_in = 9'd300; alarm_clr = 1'b1; step(); wr_en = 1'b0; alarm_clr = 1'b0;
    n_checks++;
    if ({err_sig, alarm_sig, shut_down_sig} !== 3'b100) begin
      n_errors++;
      $display("FAIL noal_300: err=%b al=%b sd=%b want 1 0 0", err_sig, alarm_sig, shut_down_sig);
    end
    drain();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0; n_errors = 0;
    test_reset();
    test_baud();
    test_format();
    test_full();
    test_random();
`ifdef UART_ALARM_EN
    test_alarm();
    test_shutdown();
`else
    test_no_alarm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_link_ctrl.md
# uart_link_ctrl

Parametrised UART link controller. It generates the baud oversample tick and the bit tick from one of four selectable divisors, and buffers host bytes in a DEPTH-entry FIFO together with their per-frame format (data bits, parity, stop bits). Entries are presented to the transmitter over a valid/ready handshake. It sits between the host write port and the UART transmitter and also raises sticky alarm and shutdown conditions on reserved command codes.

## Interface
- DIV0, 2604: divisor for bd_rate=00 (tick period DIV0+1 cycles)
- DIV1, 1302: divisor for bd_rate=01
- DIV2, 12: divisor for bd_rate=10
- DIV3, 326: divisor for bd_rate=11
- OVS, 16: oversample ratio, bd_rate_gen pulses per bd_rate_tx pulse
- DEPTH, 8: FIFO entries, power of two, ≥2
- ALARM_CODE, 250: 9-bit reserved alarm code
- SHUTDOWN_CODE, 300: 9-bit reserved shutdown code

Ports:
- clkdiv  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- bd_rate  in  2  divisor select
- par_check  in  2  parity: 00 none, 01 odd, 10 even, 11 keep previous
- s_num_sig  in  1  stop bits: 0 one, 1 two
- wr_en  in  1  host write strobe
- data_in  in  9  host word
- alarm_clr  in  1  clears alarm_sig
- full  out  1  FIFO full
- err_sig  out  1  one-cycle pulse: word dropped
- tx_valid  out  1  head entry valid
- tx_ready  in  1  transmitter accepts head
- data_in_tx  out  8  head data
- d_num  out  1  head frame: 0 = 7 data bits, 1 = 8
- par  out  2  head parity mode
- s_num  out  1  head stop-bit mode
- bd_rate_gen  out  1  oversample tick, one-cycle pulse
- bd_rate_tx  out  1  bit tick, one-cycle pulse
- alarm_sig  out  1  sticky alarm
- shut_down_sig  out  1  sticky shutdown

## Operation
- Reset (reset=0 at an edge): all outputs 0, FIFO empty, counters 0, parity register 00, alarm and shutdown cleared.
- Baud divider: 12-bit counter counts 0..DIVsel.
  - At DIVsel it returns to 0 and bd_rate_gen=1 for one cycle.
  - Any change on bd_rate restarts the counter at 0 on the next cycle, with no tick in that cycle.
- Oversample counter: 0..OVS-1, advances on bd_rate_gen. bd_rate_tx pulses in the same cycle as the bd_rate_gen that wraps it from OVS-1 to 0.
- Write classification when wr_en=1:
  - data_in==SHUTDOWN_CODE: shut_down_sig←1, FIFO flushed, nothing pushed.
  - data_in==ALARM_CODE: alarm_sig←1, nothing pushed.
  - Otherwise data_in[8]=1: dropped, err_sig pulse.
  - Otherwise, if full: dropped, err_sig pulse.
  - Otherwise: push {s_num_sig, parity register, data_in[7], data_in[7:0]}.
- A push with data_in[7]=0 marks a 7-bit frame. The transmitter ignores data_in_tx[7] in that case.
- Parity register: updated from par_check each cycle unless par_check=11. The value at push time is stored with the entry.
- Pop: when tx_valid & tx_ready. Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
- When full, a write is dropped even if a pop occurs in the same cycle.
- alarm_sig clears on alarm_clr=1 unless a new alarm write occurs in the same cycle; set wins.
- Shutdown: holds until reset.
  - Divider and oversample counters held at 0; bd_rate_gen, bd_rate_tx, tx_valid forced 0.
  - All writes ignored, with no err_sig.

## Timing
- Write to tx_valid: 1 cycle. Entry visible the cycle after the wr_en edge.
- First-word-fall-through: data_in_tx/d_num/par/s_num are registered head fields, valid whenever tx_valid=1. Contents are don't-care when tx_valid=0.
- tx_valid stays high and head contents stay stable until the pop.
- full asserts the cycle after the DEPTH-th entry is stored and deasserts the cycle after a pop.
- Tick period: (DIVsel+1) cycles for bd_rate_gen, OVS·(DIVsel+1) cycles for bd_rate_tx.
- Shutdown takes effect the cycle after the SHUTDOWN_CODE write; tx_valid is 0 from that cycle.

## Configuration
- UART_ALARM_EN defined: ALARM_CODE and SHUTDOWN_CODE behave as above.
- UART_ALARM_EN undefined:
  - No reserved codes. 250 is pushed as ordinary 8-bit data; 300 is dropped with err_sig (bit 8 set).
  - alarm_sig and shut_down_sig tied 0; alarm_clr ignored.

## Test plan
- bd_rate=10, DIV2=12, OVS=16: bd_rate_gen every 13 cycles, bd_rate_tx every 208 cycles. Switch to bd_rate=11: first tick 327 cycles after the switch.
- par_check=10, s_num_sig=1, write 0x41 then 0xC3: head 0x41 with d_num=0, par=10, s_num=1. After a pop, head 0xC3 with d_num=1.
- With tx_ready=0, write 9 words at DEPTH=8: full after the 8th, 9th dropped with err_sig pulse. Pop and write in the same full cycle: write dropped.
- Write 250: alarm_sig=1, FIFO count unchanged. alarm_clr=1 clears it. alarm_clr and a write of 250 in the same cycle: alarm_sig stays 1.
- Write 3 entries, then 300: shut_down_sig=1, tx_valid=0, ticks stop, later writes ignored. reset=0 for one edge restores ticks and an empty FIFO.
- Without UART_ALARM_EN, write 250: pushed as 0xFA with d_num=1. Write 300: err_sig pulse, alarm_sig and shut_down_sig remain 0.
